// File: rtl/gpr_regfile.sv
`default_nettype none
// ============================================================================
// Module      : gpr_regfile
// Description : General-purpose register file, NREGS x DATA_W.
//               One synchronous write port (Sc/Sin/Sw) and two independent
//               combinational read ports (Sa->Souta, Sb->Soutb).
//               Register 0 is an ordinary writable register.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Sw,
    input  logic [DATA_W-1:0] Sin,
    input  logic [ADDR_W-1:0] Sa,
    input  logic [ADDR_W-1:0] Sb,
    input  logic [ADDR_W-1:0] Sc,
    output logic [DATA_W-1:0] Souta,
    output logic [DATA_W-1:0] Soutb
);

    // Storage array; one entry per architectural register.
    logic [DATA_W-1:0] r_regs [NREGS];

    // One-hot write-enable decode of the write address.
    logic [NREGS-1:0] w_wen;

    // Decode Sc into a per-register write strobe, gated by Sw.
    always_comb begin
        w_wen = '0;
        if (Sw) begin
            w_wen[Sc] = 1'b1;
        end
    end

    // Each register clears on reset (reset beats a simultaneous write),
    // otherwise loads Sin only when its strobe is set.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_regs[gi] <= '0;
                end else if (w_wen[gi]) begin
                    r_regs[gi] <= Sin;
                end
            end
        end
    endgenerate

    // Read ports are purely combinational and do not bypass the write port:
    // a same-address read shows the old contents until the write edge.
    assign Souta = r_regs[Sa];
    assign Soutb = r_regs[Sb];

endmodule
`default_nettype wire

// File: tb/tb_gpr_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_regfile
// Description : Self-checking bench for gpr_regfile. Directed vector table
//               followed by randomized traffic against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic              clk;
    logic              rst;
    logic              Sw;
    logic [DATA_W-1:0] Sin;
    logic [ADDR_W-1:0] Sa;
    logic [ADDR_W-1:0] Sb;
    logic [ADDR_W-1:0] Sc;
    logic [DATA_W-1:0] Souta;
    logic [DATA_W-1:0] Soutb;

    gpr_regfile #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NREGS (NREGS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .Sw   (Sw),
        .Sin  (Sin),
        .Sa   (Sa),
        .Sb   (Sb),
        .Sc   (Sc),
        .Souta(Souta),
        .Soutb(Soutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain array of register contents.
    logic [DATA_W-1:0] model [NREGS];

    int n_pass;
    int n_total;

    typedef struct {
        logic              rst;
        logic              sw;
        logic [ADDR_W-1:0] sa;
        logic [ADDR_W-1:0] sb;
        logic [ADDR_W-1:0] sc;
        logic [DATA_W-1:0] sin;
        logic [DATA_W-1:0] exp_a;   // outputs expected before the edge
        logic [DATA_W-1:0] exp_b;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Apply the model's view of the upcoming edge, then clock it.
    task automatic edge_step();
        if (rst) begin
            for (int i = 0; i < NREGS; i++) model[i] = '0;
        end else if (Sw) begin
            model[Sc] = Sin;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; Sw = 1'b0; Sin = '0; Sa = '0; Sb = '0; Sc = '0;
        n_pass = 0; n_total = 0;

        //            rst  sw  sa  sb  sc  sin            exp_a          exp_b
        vecs[0]  = '{1'b0, 1'b1, 5'd0,  5'd31, 5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd0,  5'd5,  5'd5,  32'hAAAA5555, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 5'd5,  5'd10, 5'd10, 32'h12345678, 32'hAAAA5555, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 5'd5,  5'd10, 5'd0,  32'h0,        32'hAAAA5555, 32'h12345678};
        vecs[4]  = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 1'b0, 5'd15, 5'd15, 5'd0,  32'h0,        32'h0,        32'h0};
        vecs[6]  = '{1'b0, 1'b0, 5'd5,  5'd5,  5'd5,  32'hFFFFFFFF, 32'hAAAA5555, 32'hAAAA5555};
        vecs[7]  = '{1'b0, 1'b0, 5'd5,  5'd5,  5'd5,  32'hFFFFFFFF, 32'hAAAA5555, 32'hAAAA5555};
        vecs[8]  = '{1'b0, 1'b0, 5'd5,  5'd5,  5'd5,  32'hFFFFFFFF, 32'hAAAA5555, 32'hAAAA5555};
        vecs[9]  = '{1'b0, 1'b1, 5'd7,  5'd7,  5'd7,  32'hCAFEF00D, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 1'b0, 5'd7,  5'd5,  5'd0,  32'h0,        32'hCAFEF00D, 32'hAAAA5555};
        vecs[11] = '{1'b1, 1'b1, 5'd7,  5'd3,  5'd3,  32'h00000001, 32'hCAFEF00D, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 5'd3,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        vecs[13] = '{1'b0, 1'b0, 5'd5,  5'd10, 5'd0,  32'h0,        32'h0,        32'h0};

        // Reset first: contents are undefined until then.
        #2;
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        Sa = 5'd0; Sb = 5'd31;
        #1;
        check("reset_a0", Souta, 32'h0);
        check("reset_b31", Soutb, 32'h0);
        for (int i = 0; i < NREGS; i++) begin
            Sa = ADDR_W'(i);
            #1;
            check($sformatf("reset_sweep_%0d", i), Souta, 32'h0);
        end

        // Directed table: check outputs before each edge, then clock it.
        for (int v = 0; v < 14; v++) begin
            rst = vecs[v].rst; Sw = vecs[v].sw; Sa = vecs[v].sa;
            Sb = vecs[v].sb;   Sc = vecs[v].sc; Sin = vecs[v].sin;
            #1;
            check($sformatf("vec%0d_a", v), Souta, vecs[v].exp_a);
            check($sformatf("vec%0d_b", v), Soutb, vecs[v].exp_b);
            edge_step();
        end
        rst = 1'b0; Sw = 1'b0;

        // Hand sequence: read-during-write shows old value, then new after edge.
        Sw = 1'b1; Sc = 5'd0; Sa = 5'd0; Sb = 5'd31; Sin = 32'h0BADF00D;
        #1;
        check("rdw_before", Souta, 32'h0);
        edge_step();
        Sw = 1'b0;
        #1;
        check("rdw_after", Souta, 32'h0BADF00D);

        // Randomized traffic against the array model.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            Sw  = $urandom_range(0, 1) == 1;
            Sc  = ADDR_W'($urandom);
            Sa  = ($urandom_range(0, 3) == 0) ? Sc : ADDR_W'($urandom);
            Sb  = ($urandom_range(0, 3) == 0) ? Sa : ADDR_W'($urandom);
            Sin = $urandom;
            #1;
            check("rand_a", Souta, model[Sa]);
            check("rand_b", Soutb, model[Sb]);
            edge_step();
        end
        rst = 1'b0; Sw = 1'b0;

        // Final sweep of all registers against the model.
        for (int i = 0; i < NREGS; i++) begin
            Sa = ADDR_W'(i); Sb = ADDR_W'(NREGS - 1 - i);
            #1;
            check("final_a", Souta, model[i]);
            check("final_b", Soutb, model[NREGS - 1 - i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
